sad_min_search: RTL and testbench

//  Reader for the SAD result memory (C memory): after Go, walks NUM_BLOCKS result words,

---
 rtl/sad_min_search.sv | 177 +++++++++++++++++
 tb/tb_sad_min_search.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_search.sv
// Minimum-SAD search over the result memory: scans NUM_BLOCKS words and reports the smallest value and its address.
// Optional SAD_EARLY_EXIT_EN adds Thresh/Hit and stops the scan at the first word at or below Thresh.
module sad_min_search #(
   parameter int NUM_BLOCKS = 128,
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Go,
   output logic [ADDR_W-1:0] C_Addr,
   output logic              C_RW,
   output logic              C_En,
   input  logic [DATA_W-1:0] C_Data,
   output logic [DATA_W-1:0] Min_Out,
   output logic [ADDR_W-1:0] Min_Idx,
   output logic              Busy,
`ifdef SAD_EARLY_EXIT_EN
   input  logic [DATA_W-1:0] Thresh,
   output logic              Hit,
`endif
   output logic              Done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ISSUE,
      S_WAIT,
      S_CAP,
      S_DONE
   } state_t;

   // One extra bit so a scan of exactly 2**ADDR_W words cannot wrap before the last one
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BLOCKS - 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  idx, idx_nx;
   logic [DATA_W-1:0] run_min, run_min_nx;
   logic [ADDR_W-1:0] run_idx, run_idx_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic              en_nx;
   logic              done_nx;
   logic              busy_nx;
   logic [DATA_W-1:0] min_out_nx;
   logic [ADDR_W-1:0] min_idx_nx;

`ifdef SAD_EARLY_EXIT_EN
   logic [DATA_W-1:0] thresh_q;
   logic              hit_run, hit_run_nx;
   logic              hit_nx;
`endif

   function automatic logic is_lower(input logic [DATA_W-1:0] cand,
                                     input logic [DATA_W-1:0] best);
      return cand < best;
   endfunction

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      run_min_nx = run_min;
      run_idx_nx = run_idx;
      addr_nx    = C_Addr;
      en_nx      = 1'b0;
      done_nx    = 1'b0;
      busy_nx    = Busy;
      min_out_nx = Min_Out;
      min_idx_nx = Min_Idx;
`ifdef SAD_EARLY_EXIT_EN
      hit_run_nx = hit_run;
      hit_nx     = Hit;
`endif
      case (state)
         S_IDLE: begin
            if (Go) begin
               state_nx = S_INIT;
               busy_nx  = 1'b1;
            end
         end
         S_INIT: begin
            idx_nx     = '0;
            run_min_nx = '1;
            run_idx_nx = '0;
            busy_nx    = 1'b1;
`ifdef SAD_EARLY_EXIT_EN
            hit_run_nx = 1'b0;
`endif
            state_nx   = S_ISSUE;
         end
         S_ISSUE: begin
            addr_nx  = idx[ADDR_W-1:0];
            en_nx    = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            state_nx = S_CAP;
         end
         S_CAP: begin
            if (is_lower(C_Data, run_min)) begin
               run_min_nx = C_Data;
               run_idx_nx = idx[ADDR_W-1:0];
            end
            idx_nx   = idx + 1'b1;
            state_nx = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
`ifdef SAD_EARLY_EXIT_EN
            // A word at or below threshold is taken as the answer even if not the smallest so far
            if (C_Data <= thresh_q) begin
               run_min_nx = C_Data;
               run_idx_nx = idx[ADDR_W-1:0];
               hit_run_nx = 1'b1;
               state_nx   = S_DONE;
            end
`endif
         end
         S_DONE: begin
            min_out_nx = run_min;
            min_idx_nx = run_idx;
            done_nx    = 1'b1;
            busy_nx    = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            hit_nx     = hit_run;
`endif
            state_nx   = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         run_min <= '1;
         run_idx <= '0;
         C_Addr  <= '0;
         C_RW    <= 1'b0;
         C_En    <= 1'b0;
         Min_Out <= '0;
         Min_Idx <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
         hit_run <= 1'b0;
         Hit     <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         run_min <= run_min_nx;
         run_idx <= run_idx_nx;
         C_Addr  <= addr_nx;
         C_RW    <= 1'b0;
         C_En    <= en_nx;
         Min_Out <= min_out_nx;
         Min_Idx <= min_idx_nx;
         Busy    <= busy_nx;
         Done    <= done_nx;
`ifdef SAD_EARLY_EXIT_EN
         hit_run <= hit_run_nx;
         Hit     <= hit_nx;
`endif
      end
   end

`ifdef SAD_EARLY_EXIT_EN
   always_ff @(posedge Clk) begin
      if (state == S_INIT) begin
         thresh_q <= Thresh;
      end
   end
`endif

endmodule

// File: tb/tb_sad_min_search.sv
// Scoreboard bench for sad_min_search: stimulus queues expected results, a monitor checks each Done.
// Define SAD_EARLY_EXIT_EN to also exercise the threshold early-exit ports.
module tb_sad_min_search;

   localparam int NB  = 128;
   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int LAT = 3 * NB + 2;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Go;
   logic [AW-1:0] C_Addr;
   logic          C_RW;
   logic          C_En;
   logic [DW-1:0] C_Data;
   logic [DW-1:0] Min_Out;
   logic [AW-1:0] Min_Idx;
   logic          Busy;
   logic          Done;
`ifdef SAD_EARLY_EXIT_EN
   logic [DW-1:0] Thresh;
   logic          Hit;
`endif

   sad_min_search #(.NUM_BLOCKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Go     (Go),
      .C_Addr (C_Addr),
      .C_RW   (C_RW),
      .C_En   (C_En),
      .C_Data (C_Data),
      .Min_Out(Min_Out),
      .Min_Idx(Min_Idx),
      .Busy   (Busy),
`ifdef SAD_EARLY_EXIT_EN
      .Thresh (Thresh),
      .Hit    (Hit),
`endif
      .Done   (Done)
   );

   always #5 Clk = ~Clk;

   // Result memory: registered read, data presented two edges after C_En appears
   logic [DW-1:0] mem [NB];
   logic [DW-1:0] rdata = '0;
   always @(posedge Clk) if (C_En) rdata <= mem[C_Addr];
   assign C_Data = rdata;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] mn;
      logic [AW-1:0] ix;
      int            done_cyc;
      int            n_en;
      logic          hit;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge Clk) begin
      exp_t e;
      if (Rst) begin
         en_cnt = 0;
      end else begin
         if (C_En) begin
            chk("c_addr", DW'(C_Addr), DW'(en_cnt));
            en_cnt++;
         end
         if (Done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got Done at cycle %0d, required none", cyc);
            end else begin
               e = sb.pop_front();
               chk("min_out",   Min_Out, e.mn);
               chk("min_idx",   DW'(Min_Idx), DW'(e.ix));
               chk("done_cyc",  DW'(cyc), DW'(e.done_cyc));
               chk("en_count",  DW'(en_cnt), DW'(e.n_en));
               chk("busy_done", DW'(Busy), '0);
               chk("c_rw",      DW'(C_RW), '0);
`ifdef SAD_EARLY_EXIT_EN
               chk("hit",       DW'(Hit), DW'(e.hit));
`endif
            end
            en_cnt = 0;
         end
      end
   end

   task automatic start_scan(input logic [DW-1:0] mn, input logic [AW-1:0] ix, input int lat,
                             input int nen, input logic hit, input bit push);
      exp_t e;
      @(negedge Clk);
      Go = 1'b1;
      if (push) begin
         e.mn = mn; e.ix = ix; e.done_cyc = cyc + 1 + lat; e.n_en = nen; e.hit = hit;
         sb.push_back(e);
      end
      @(negedge Clk);
      Go = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge Clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got %0d outstanding results, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      exp_t e;
      int   c0;
      Rst = 1'b1;
      Go  = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
      Thresh = '0;
`endif
      for (int i = 0; i < NB; i++) mem[i] = DW'(1000 - i);

      // Reset held three cycles
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk("rst_c_en", DW'(C_En), '0);
         chk("rst_busy", DW'(Busy), '0);
      end
      Rst = 1'b0;
      @(negedge Clk);
      chk("rst_c_addr",  DW'(C_Addr), '0);
      chk("rst_c_rw",    DW'(C_RW), '0);
      chk("rst_min_out", Min_Out, '0);
      chk("rst_min_idx", DW'(Min_Idx), '0);
      chk("rst_done",    DW'(Done), '0);

      // Descending values: minimum in the last word
      start_scan(873, 127, LAT, NB, 1'b0, 1'b1);
      wait_idle(LAT + 20);

      // Tie between addresses 5 and 90; previous result must hold during the scan
      for (int i = 0; i < NB; i++) mem[i] = 500;
      mem[5]  = 7;
      mem[90] = 7;
      start_scan(7, 5, LAT, NB, 1'b0, 1'b1);
      repeat (20) @(negedge Clk);
      chk("busy_mid", DW'(Busy), 1);
      chk("hold_min", Min_Out, 873);
      chk("hold_idx", DW'(Min_Idx), 127);
      wait_idle(LAT + 20);

      // Go pulses mid-scan are ignored
      start_scan(7, 5, LAT, NB, 1'b0, 1'b1);
      repeat (8) @(negedge Clk);
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      repeat (39) @(negedge Clk);
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      wait_idle(LAT + 20);
      repeat (20) @(negedge Clk);
      chk("busy_after", DW'(Busy), '0);

      // All words all-ones
      for (int i = 0; i < NB; i++) mem[i] = '1;
      start_scan('1, 0, LAT, NB, 1'b0, 1'b1);
      wait_idle(LAT + 20);

      // Go held high: back-to-back scans
      for (int i = 0; i < NB; i++) mem[i] = DW'(1000 - i);
      @(negedge Clk);
      c0 = cyc;
      Go = 1'b1;
      e.mn = 873; e.ix = 127; e.n_en = NB; e.hit = 1'b0;
      e.done_cyc = c0 + 1 + LAT;
      sb.push_back(e);
      e.done_cyc = c0 + 1 + LAT + 1 + LAT;
      sb.push_back(e);
      repeat (LAT + 14) @(negedge Clk);
      Go = 1'b0;
      wait_idle(LAT + 40);

      // Reset at word 60 aborts the scan
      start_scan(0, 0, 0, 0, 1'b0, 1'b0);
      repeat (3 * 60) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      chk("abort_busy",    DW'(Busy), '0);
      chk("abort_min_out", Min_Out, '0);
      chk("abort_min_idx", DW'(Min_Idx), '0);
      chk("abort_c_en",    DW'(C_En), '0);
      repeat (LAT) @(negedge Clk);
      for (int i = 0; i < NB; i++) mem[i] = DW'(300 + i);
      start_scan(300, 0, LAT, NB, 1'b0, 1'b1);
      wait_idle(LAT + 20);

`ifdef SAD_EARLY_EXIT_EN
      // Threshold early exit at word 40, then a threshold no word meets
      for (int i = 0; i < NB; i++) mem[i] = 100;
      mem[40] = 15;
      Thresh  = 20;
      start_scan(15, 40, 3 * 40 + 5, 41, 1'b1, 1'b1);
      wait_idle(LAT + 20);
      Thresh = 10;
      start_scan(15, 40, LAT, NB, 1'b0, 1'b1);
      wait_idle(LAT + 20);
`endif

      repeat (5) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
